// File: rtl/synth_ci_pkg.sv
// Shared types and helpers for the synth_ci_mac custom instruction.
// Holds the opcode/state enums, a clog2 helper and a generic signed saturator.
package synth_ci_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'd0,
    OP_MAC   = 2'd1,
    OP_RDCLR = 2'd2,
    OP_LOAD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam int SAT_MAX_W = 128;

  function automatic int clog2(input int value);
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) >= value) return r;
    end
    return 31;
  endfunction

  // Values are carried sign-extended in SAT_MAX_W bits; the caller slices the low outW bits.
  function automatic logic signed [SAT_MAX_W-1:0] saturate(input logic signed [SAT_MAX_W-1:0] x,
                                                          input int outW);
    logic signed [SAT_MAX_W-1:0] maxV;
    logic signed [SAT_MAX_W-1:0] minV;
    maxV = $signed((SAT_MAX_W'(1) << (outW - 1)) - SAT_MAX_W'(1));
    minV = ~maxV;
    if (x > maxV) return maxV;
    if (x < minV) return minV;
    return x;
  endfunction

endpackage

// File: rtl/synth_ci_mac_if.sv
// Nios II custom-instruction slot signals between the CPU (master) and synth_ci_mac (slave).
interface synth_ci_mac_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [DATA_W-1:0] dataa;
  logic [DATA_W-1:0] datab;
  logic [7:0]        n;
  logic              done;
  logic [DATA_W-1:0] result;

  modport master (output start, dataa, datab, n, input done, result);
  modport slave  (input start, dataa, datab, n, output done, result);
endinterface

// File: rtl/synth_ci_shift_add_mul.sv
// Unsigned iterative shift-add multiplier retiring BPC multiplier bits per step.
// Product sits in {hi, lo}: lo starts as the multiplier and is shifted out as partial sums shift in.
module synth_ci_shift_add_mul
  import synth_ci_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BPC    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic                step_i,
  input  logic [DATA_W-1:0]   mcand_i,
  input  logic [DATA_W-1:0]   mplier_i,
  output logic [2*DATA_W-1:0] product_o,
  output logic                busy_o,
  output logic                last_o
);

  localparam int STEPS = DATA_W / BPC;
  localparam int CNT_W = clog2(STEPS + 1);

  logic [DATA_W-1:0]     hi_q, lo_q, mcand_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W+BPC-1:0] sum_d;

  always_comb begin
    sum_d = {{BPC{1'b0}}, hi_q};
    for (int k = 0; k < BPC; k++) begin
      if (lo_q[k]) sum_d = sum_d + ({{BPC{1'b0}}, mcand_q} << k);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      hi_q    <= '0;
      lo_q    <= mplier_i;
      mcand_q <= mcand_i;
      cnt_q   <= CNT_W'(STEPS);
    end else if (step_i && (cnt_q != '0)) begin
      hi_q  <= sum_d[DATA_W+BPC-1:BPC];
      lo_q  <= {sum_d[BPC-1:0], lo_q[DATA_W-1:BPC]};
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign product_o = {hi_q, lo_q};
  assign busy_o    = (cnt_q != '0);
  assign last_o    = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/synth_ci_mac.sv
// Signed fixed-point MUL/MAC custom instruction with N_ACC accumulators.
// Define SYNTH_CI_SAT_EN to saturate results to DATA_W; otherwise results wrap.
module synth_ci_mac
  import synth_ci_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int FRAC_W  = 15,
  parameter int N_ACC   = 4,
  parameter int GUARD_W = 8,
  parameter int BPC     = 1
) (
  input logic           clk,
  input logic           reset,
  input logic           clk_en,
  synth_ci_mac_if.slave ci
);

  localparam int ACC_W  = DATA_W + GUARD_W;
  localparam int PROD_W = 2 * DATA_W;
  localparam int IDX_W  = (N_ACC > 1) ? clog2(N_ACC) : 1;

  state_e                   state_q;
  op_e                      op_q;
  logic [IDX_W-1:0]         accIdx_q;
  logic                     sign_q;
  logic signed [ACC_W-1:0]  acc_q [N_ACC];
  logic                     done_q;
  logic [DATA_W-1:0]        result_q;

  op_e                      startOp;
  logic [IDX_W-1:0]         startIdx;
  logic [DATA_W-1:0]        magA, magB;
  logic                     mulLoad, mulStep, mulBusy, mulLast;
  logic [PROD_W-1:0]        mulProduct;
  logic signed [PROD_W-1:0] signedProd, scaledProd;
  logic signed [ACC_W-1:0]  macSum;

  function automatic logic [DATA_W-1:0] fitOut(input logic signed [SAT_MAX_W-1:0] x);
    logic signed [SAT_MAX_W-1:0] y;
`ifdef SYNTH_CI_SAT_EN
    y = saturate(x, DATA_W);
`else
    y = x;
`endif
    return y[DATA_W-1:0];
  endfunction

  assign startOp  = op_e'(ci.n[1:0]);
  assign startIdx = (N_ACC > 1) ? ci.n[2 +: IDX_W] : '0;

  // The most negative operand negates to itself, which is still the right unsigned magnitude.
  assign magA = ci.dataa[DATA_W-1] ? (-ci.dataa) : ci.dataa;
  assign magB = ci.datab[DATA_W-1] ? (-ci.datab) : ci.datab;

  assign mulLoad = clk_en && (state_q == ST_IDLE) && ci.start &&
                   ((startOp == OP_MUL) || (startOp == OP_MAC));
  assign mulStep = clk_en && (state_q == ST_RUN) && mulBusy;

  synth_ci_shift_add_mul #(
    .DATA_W(DATA_W),
    .BPC   (BPC)
  ) u_mul (
    .clk      (clk),
    .reset    (reset),
    .load_i   (mulLoad),
    .step_i   (mulStep),
    .mcand_i  (magA),
    .mplier_i (magB),
    .product_o(mulProduct),
    .busy_o   (mulBusy),
    .last_o   (mulLast)
  );

  always_comb begin
    signedProd = sign_q ? -$signed(mulProduct) : $signed(mulProduct);
    scaledProd = signedProd >>> FRAC_W;
    macSum     = acc_q[accIdx_q] + scaledProd[ACC_W-1:0];
  end

  // RDCLR/LOAD complete on the issuing edge; MUL/MAC walk RUN then finish in FIN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      accIdx_q <= '0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      for (int k = 0; k < N_ACC; k++) acc_q[k] <= '0;
    end else if (clk_en) begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ci.start) begin
            op_q     <= startOp;
            accIdx_q <= startIdx;
            sign_q   <= ci.dataa[DATA_W-1] ^ ci.datab[DATA_W-1];
            case (startOp)
              OP_RDCLR: begin
                result_q        <= fitOut(SAT_MAX_W'(acc_q[startIdx]));
                acc_q[startIdx] <= '0;
                done_q          <= 1'b1;
              end
              OP_LOAD: begin
                result_q        <= ci.dataa;
                acc_q[startIdx] <= ACC_W'($signed(ci.dataa));
                done_q          <= 1'b1;
              end
              default: state_q <= ST_RUN;
            endcase
          end
        end
        ST_RUN: begin
          if (mulLast) state_q <= ST_FIN;
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
          if (op_q == OP_MAC) begin
            acc_q[accIdx_q] <= macSum;
            result_q        <= fitOut(SAT_MAX_W'(macSum));
          end else begin
            result_q <= fitOut(SAT_MAX_W'(scaledProd));
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ci.done   = done_q;
  assign ci.result = result_q;

endmodule

// File: tb/tb_synth_ci_mac.sv
// Bench for synth_ci_mac: arithmetic reference model compared every cycle plus pinned literal cases.
// Honours SYNTH_CI_SAT_EN the same way the design does.
module tb_synth_ci_mac;

  localparam int DW    = 32;
  localparam int FW    = 15;
  localparam int NACC  = 4;
  localparam int AW    = 40;
  localparam int STEPS = 32;

  logic clk;
  logic reset;
  logic clkEn;

  synth_ci_mac_if #(.DATA_W(DW)) ci  ();
  synth_ci_mac_if #(.DATA_W(DW)) ci4 ();

  synth_ci_mac #(.DATA_W(DW), .FRAC_W(FW), .N_ACC(NACC), .GUARD_W(8), .BPC(1)) u_dut (
    .clk(clk), .reset(reset), .clk_en(clkEn), .ci(ci)
  );

  synth_ci_mac #(.DATA_W(DW), .FRAC_W(FW), .N_ACC(NACC), .GUARD_W(8), .BPC(4)) u_dut4 (
    .clk(clk), .reset(reset), .clk_en(clkEn), .ci(ci4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nVectors    = 0;
  int nMiscompares = 0;
  bit checkEnable = 1'b0;

  // Reference model state
  longint      accModel [NACC];
  bit          mBusy = 1'b0;
  int          mEdge = 0;
  int          mFinishEdge = 0;
  bit          mIsMac;
  int          mIdx;
  longint      mA, mB;
  bit          modelDone = 1'b0;
  logic [31:0] modelResult = '0;

  function automatic longint wrapAcc(input longint x);
    return (x <<< (64 - AW)) >>> (64 - AW);
  endfunction

  function automatic logic [31:0] toOut(input longint x);
`ifdef SYNTH_CI_SAT_EN
    if (x > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (x < -64'sd2147483648) return 32'h8000_0000;
`endif
    return x[31:0];
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      mBusy       = 1'b0;
      modelDone   = 1'b0;
      modelResult = '0;
      foreach (accModel[k]) accModel[k] = 0;
    end else if (clkEn) begin
      mEdge++;
      modelDone = 1'b0;
      if (mBusy) begin
        if (mEdge == mFinishEdge) begin
          longint scaled;
          scaled = (mA * mB) >>> FW;
          if (mIsMac) begin
            accModel[mIdx] = wrapAcc(accModel[mIdx] + scaled);
            modelResult    = toOut(accModel[mIdx]);
          end else begin
            modelResult = toOut(scaled);
          end
          mBusy     = 1'b0;
          modelDone = 1'b1;
        end
      end else if (ci.start) begin
        int op;
        int idx;
        op  = int'(ci.n) % 4;
        idx = (int'(ci.n) / 4) % NACC;
        case (op)
          0, 1: begin
            mBusy       = 1'b1;
            mFinishEdge = mEdge + STEPS + 1;
            mIsMac      = (op == 1);
            mIdx        = idx;
            mA          = longint'($signed(ci.dataa));
            mB          = longint'($signed(ci.datab));
          end
          2: begin
            modelResult   = toOut(accModel[idx]);
            accModel[idx] = 0;
            modelDone     = 1'b1;
          end
          default: begin
            accModel[idx] = longint'($signed(ci.dataa));
            modelResult   = ci.dataa;
            modelDone     = 1'b1;
          end
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEnable) begin
      checkOutput("cycle_done", 64'(ci.done), 64'(modelDone));
      checkOutput("cycle_result", 64'(ci.result), 64'(modelResult));
    end
  end

  // Issues one instruction and waits for done; lat counts edges from the start-sampling edge inclusive.
  task automatic applyStimulus(input logic [1:0] op, input int idx, input logic [31:0] a,
                               input logic [31:0] b, input int stallAt, input int resetAt,
                               input bit pulseBusy, output int lat, output bit timedOut);
    @(posedge clk); #2;
    ci.start = 1'b1;
    ci.n     = {idx[5:0], op};
    ci.dataa = a;
    ci.datab = b;
    @(posedge clk);
    lat = 1;
    #2;
    ci.start = 1'b0;
    timedOut = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ci.done) begin
        timedOut = 1'b0;
        break;
      end
      @(posedge clk);
      lat++;
      #2;
      if (stallAt > 0 && lat == stallAt) clkEn = 1'b0;
      if (stallAt > 0 && lat == stallAt + 5) clkEn = 1'b1;
      if (pulseBusy && lat == 3) begin
        ci.start = 1'b1;
        ci.n     = 8'h0A;
      end
      if (pulseBusy && lat == 4) ci.start = 1'b0;
      if (resetAt > 0 && lat == resetAt) reset = 1'b0;
      if (resetAt > 0 && lat == resetAt + 1) begin
        reset    = 1'b1;
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic runOp(input string name, input logic [1:0] op, input int idx, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes, input int expLat,
                       input int stallAt, input bit pulseBusy);
    int lat;
    bit timedOut;
    applyStimulus(op, idx, a, b, stallAt, 0, pulseBusy, lat, timedOut);
    checkOutput({name, "_timeout"}, 64'(timedOut), 64'd0);
    checkOutput({name, "_result"}, 64'(ci.result), 64'(expRes));
    checkOutput({name, "_latency"}, 64'(lat), 64'(expLat));
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, "_donewidth"}, 64'(ci.done), 64'd0);
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] t;
    case ($urandom_range(0, 7))
      0: t = 32'h8000_0000;
      1: t = 32'h7FFF_FFFF;
      2: t = 32'hFFFF_FFFF;
      3: t = 32'h0000_0000;
      4: t = $urandom_range(0, 65535);
      5: begin
        t = $urandom_range(0, 65535);
        t = -t;
      end
      default: t = $urandom;
    endcase
    return t;
  endfunction

  localparam logic [31:0] SAT_EXP =
`ifdef SYNTH_CI_SAT_EN
    32'h7FFF_FFFF;
`else
    32'h8000_0000;
`endif

  initial begin
    int lat;
    bit timedOut;
    reset    = 1'b0;
    clkEn    = 1'b0;
    ci.start = 1'b0;  ci.n = '0;  ci.dataa = '0;  ci.datab = '0;
    ci4.start = 1'b0; ci4.n = '0; ci4.dataa = '0; ci4.datab = '0;

    @(posedge clk); #2;
    checkEnable = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_done", 64'(ci.done), 64'd0);
    checkOutput("reset_result", 64'(ci.result), 64'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    clkEn = 1'b1;

    $display("[TB] directed multiply cases");
    runOp("mul_pos", 2'd0, 0, 32'h0000_8000, 32'h0000_4000, 32'h0000_4000, 34, 0, 1'b0);
    runOp("mul_neg", 2'd0, 0, 32'hFFFF_8000, 32'h0000_4000, 32'hFFFF_C000, 34, 0, 1'b0);
    runOp("mul_floor", 2'd0, 0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 34, 0, 1'b0);

    $display("[TB] accumulator cases");
    runOp("load_acc1", 2'd3, 1, 32'h0000_0055, 32'h0, 32'h0000_0055, 1, 0, 1'b0);
    runOp("load_acc2", 2'd3, 2, 32'h0000_0100, 32'h0, 32'h0000_0100, 1, 0, 1'b0);
    runOp("mac_acc2", 2'd1, 2, 32'h0000_8000, 32'h0000_0200, 32'h0000_0300, 34, 0, 1'b0);
    runOp("rdclr_acc2_hiidx", 2'd2, 6, 32'h0, 32'h0, 32'h0000_0300, 1, 0, 1'b0);
    runOp("rdclr_acc2_again", 2'd2, 2, 32'h0, 32'h0, 32'h0000_0000, 1, 0, 1'b0);
    runOp("rdclr_acc1", 2'd2, 1, 32'h0, 32'h0, 32'h0000_0055, 1, 0, 1'b0);

    runOp("load_acc0_max", 2'd3, 0, 32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFFF, 1, 0, 1'b0);
    runOp("mac_acc0_ovf", 2'd1, 0, 32'h0000_8000, 32'h0000_0001, SAT_EXP, 34, 0, 1'b0);
    runOp("rdclr_acc0_ovf", 2'd2, 0, 32'h0, 32'h0, SAT_EXP, 1, 0, 1'b0);

    $display("[TB] clock-enable stall with ignored start pulses");
    runOp("mul_stall", 2'd0, 0, 32'h0000_8000, 32'h0000_4000, 32'h0000_4000, 39, 10, 1'b1);

    $display("[TB] reset during RUN");
    runOp("load_acc2_pre", 2'd3, 2, 32'h0000_1234, 32'h0, 32'h0000_1234, 1, 0, 1'b0);
    applyStimulus(2'd0, 0, 32'h0001_0000, 32'h0001_0000, 0, 10, 1'b0, lat, timedOut);
    @(negedge clk);
    checkOutput("midrun_reset_done", 64'(ci.done), 64'd0);
    checkOutput("midrun_reset_result", 64'(ci.result), 64'd0);
    runOp("rdclr_acc2_post", 2'd2, 2, 32'h0, 32'h0, 32'h0000_0000, 1, 0, 1'b0);

    $display("[TB] four bits per cycle");
    @(posedge clk); #2;
    ci4.start = 1'b1; ci4.n = 8'h00; ci4.dataa = 32'hFFFF_0000; ci4.datab = 32'h0003_0000;
    @(posedge clk);
    lat = 1;
    #2;
    ci4.start = 1'b0;
    timedOut = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ci4.done) begin
        timedOut = 1'b0;
        break;
      end
      @(posedge clk);
      lat++;
    end
    checkOutput("bpc4_timeout", 64'(timedOut), 64'd0);
    checkOutput("bpc4_latency", 64'(lat), 64'd10);
    checkOutput("bpc4_result", 64'(ci4.result), 64'hFFFA_0000);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      clkEn    = ($urandom_range(0, 99) < 85);
      reset    = ($urandom_range(0, 599) != 0);
      ci.start = ($urandom_range(0, 99) < 25);
      ci.n     = 8'($urandom);
      ci.dataa = pickOperand();
      ci.datab = pickOperand();
    end
    @(posedge clk); #2;
    ci.start = 1'b0;
    clkEn    = 1'b1;
    reset    = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
